// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory fetch bus.
//   master (fetch stage): drives IMemAddr / IMemReq, samples IMemReady / IMemRdata
//   slave  (memory)     : returns IMemRdata in the same cycle IMemReady is high;
//                         wait states are inserted by holding IMemReady low.
interface instr_fetch_stage_if;
  logic [31:0] IMemAddr;
  logic        IMemReq;
  logic        IMemReady;
  logic [31:0] IMemRdata;

  modport master (
    output IMemAddr,
    output IMemReq,
    input  IMemReady,
    input  IMemRdata
  );

  modport slave (
    input  IMemAddr,
    input  IMemReq,
    output IMemReady,
    output IMemRdata
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage and IF/ID pipeline register of the RISC-V core.
// Holds PCF, fetches over the imem ready handshake and registers the fetched
// word into decode together with the pre-decoded immediate format select
// (SrcExtD) and the immediate field (ImmD = InstrD[31:7]).
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   StallF / StallD   hold PC / hold IF/ID register
//   FlushD            load a bubble into IF/ID
//   PCSrcE, PCTargetE redirect from execute (discards the fetch in flight)
//   imem              fetch bus (master side)
//   InstrD, PCD, PCPlus4D, ImmD, SrcExtD, ValidD   decode-stage outputs
//
// state  | meaning
// -------+----------------------------------------------------------
// BOOT   | one cycle after reset, no request, PC held
// FETCH  | IMemReq high, IMemAddr = PCF, stays here until reset
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StallF,
  input  logic                       StallD,
  input  logic                       FlushD,
  input  logic                       PCSrcE,
  input  logic [31:0]                PCTargetE,
  instr_fetch_stage_if.master        imem,
  output logic [31:0]                InstrD,
  output logic [31:0]                PCD,
  output logic [31:0]                PCPlus4D,
  output logic [24:0]                ImmD,
  output logic [2:0]                 SrcExtD,
  output logic                       ValidD
);

  localparam logic [2:0] SRC_EXT_NOP = 3'b001;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [2:0]  src_ext_q, src_ext_d;
  logic        valid_q, valid_d;

  logic        fetch_done;
  logic [31:0] pc_plus4_f;

  function automatic logic [2:0] decode_src_ext(input logic [6:0] opcode,
                                                input logic [2:0] funct3);
    logic [2:0] sel;
    sel = 3'b000;
    case (opcode)
      7'b0010011: sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b110 : 3'b001;
      7'b0000011,
      7'b1100111: sel = 3'b001;
      7'b0100011: sel = 3'b010;
      7'b1100011: sel = 3'b011;
      7'b0110111,
      7'b0010111: sel = 3'b100;
      7'b1101111: sel = 3'b101;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

  assign pc_plus4_f = pc_q + 32'd4;
  assign fetch_done = (state_q == ST_FETCH) && imem.IMemReady && !StallF;

  always_comb begin
    state_d    = ST_FETCH;
    imem_req_d = 1'b1;

    pc_d = pc_q;
    if (PCSrcE) begin
      pc_d = PCTargetE;
    end else if (StallF) begin
      pc_d = pc_q;
    end else if (fetch_done) begin
      pc_d = pc_plus4_f;
    end

    // Bubble by default; PCD/PCPlus4D keep their last values on a bubble.
    instr_d    = NOP_INSTR;
    src_ext_d  = SRC_EXT_NOP;
    valid_d    = 1'b0;
    pc_dec_d   = pc_dec_q;
    pc_plus4_d = pc_plus4_q;
    if (FlushD || PCSrcE) begin
      instr_d = NOP_INSTR;
    end else if (StallD) begin
      instr_d   = instr_q;
      src_ext_d = src_ext_q;
      valid_d   = valid_q;
    end else if (fetch_done) begin
      instr_d    = imem.IMemRdata;
      src_ext_d  = decode_src_ext(imem.IMemRdata[6:0], imem.IMemRdata[14:12]);
      valid_d    = 1'b1;
      pc_dec_d   = pc_q;
      pc_plus4_d = pc_plus4_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      imem_req_q <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_dec_q   <= 32'h0;
      pc_plus4_q <= 32'h0;
      src_ext_q  <= SRC_EXT_NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_dec_q   <= pc_dec_d;
      pc_plus4_q <= pc_plus4_d;
      src_ext_q  <= src_ext_d;
      valid_q    <= valid_d;
    end
  end

  assign imem.IMemAddr = pc_q;
  assign imem.IMemReq  = imem_req_q;

  assign InstrD   = instr_q;
  assign PCD      = pc_dec_q;
  assign PCPlus4D = pc_plus4_q;
  assign ImmD     = instr_q[31:7];
  assign SrcExtD  = src_ext_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: combinational instruction memory
// indexed by IMemAddr[5:2], inputs driven 1 time unit after each rising edge,
// outputs checked in the same window.
module tb_instr_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic [24:0] ImmD;
  logic [2:0]  SrcExtD;
  logic        ValidD;

  logic [31:0] mem [16];
  int          tests_run;
  int          tests_failed;

  instr_fetch_stage_if imem_if ();

  instr_fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_if.master),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ImmD      (ImmD),
    .SrcExtD   (SrcExtD),
    .ValidD    (ValidD)
  );

  assign imem_if.IMemRdata = mem[imem_if.IMemAddr[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n)
      assert (!(StallD && !StallF && imem_if.IMemReq && imem_if.IMemReady))
        else $error("illegal stall combination: StallD with StallF low on a completing fetch");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++; if (imem_if.IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b exp 0", imem_if.IMemReq); end
    tests_run++; if (imem_if.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL rst_pc: got %h exp 00000000", imem_if.IMemAddr); end
    tests_run++; if (InstrD !== 32'h13) begin tests_failed++; $display("FAIL rst_instr: got %h exp 00000013", InstrD); end
    tests_run++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin tests_failed++; $display("FAIL rst_pcd: got %h/%h exp 0/0", PCD, PCPlus4D); end
    tests_run++; if (SrcExtD !== 3'b001) begin tests_failed++; $display("FAIL rst_srcext: got %b exp 001", SrcExtD); end
    tests_run++; if (ValidD !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b exp 0", ValidD); end
    tests_run++; if (ImmD !== 25'h0) begin tests_failed++; $display("FAIL rst_imm: got %h exp 0000000", ImmD); end
  endtask

  task automatic test_boot_fetch();
    rst_n = 1'b1;
    tests_run++; if (imem_if.IMemReq !== 1'b0) begin tests_failed++; $display("FAIL boot_req: got %b exp 0", imem_if.IMemReq); end
    tick();
    tests_run++; if (imem_if.IMemReq !== 1'b1 || imem_if.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL fetch0: req %b addr %h exp 1/00000000", imem_if.IMemReq, imem_if.IMemAddr); end
    tests_run++; if (ValidD !== 1'b0) begin tests_failed++; $display("FAIL fetch0_valid: got %b exp 0", ValidD); end
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'h4) begin tests_failed++; $display("FAIL fetch1_addr: got %h exp 00000004", imem_if.IMemAddr); end
    tests_run++; if (InstrD !== 32'h00500093 || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin tests_failed++; $display("FAIL instr0: got %h pc %h pc4 %h exp 00500093/0/4", InstrD, PCD, PCPlus4D); end
    tests_run++; if (SrcExtD !== 3'b001 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL instr0_ctl: srcext %b valid %b exp 001/1", SrcExtD, ValidD); end
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'h8) begin tests_failed++; $display("FAIL fetch2_addr: got %h exp 00000008", imem_if.IMemAddr); end
    tests_run++; if (InstrD !== 32'h00A00113 || PCD !== 32'h4 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL instr1: got %h pc %h valid %b exp 00a00113/4/1", InstrD, PCD, ValidD); end
  endtask

  task automatic test_mem_wait();
    imem_if.IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (imem_if.IMemAddr !== 32'h8 || ValidD !== 1'b0) begin tests_failed++; $display("FAIL wait%0d: addr %h valid %b exp 00000008/0", i, imem_if.IMemAddr, ValidD); end
    end
    imem_if.IMemReady = 1'b1;
    tick();
    tests_run++; if (InstrD !== 32'h00F00193 || PCD !== 32'h8 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL wait_land: got %h pc %h valid %b exp 00f00193/8/1", InstrD, PCD, ValidD); end
    tests_run++; if (imem_if.IMemAddr !== 32'hC) begin tests_failed++; $display("FAIL wait_next: got %h exp 0000000c", imem_if.IMemAddr); end
  endtask

  task automatic test_redirect();
    imem_if.IMemReady = 1'b0; StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'h100) begin tests_failed++; $display("FAIL redir_pc: got %h exp 00000100", imem_if.IMemAddr); end
    tests_run++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin tests_failed++; $display("FAIL redir_bubble: instr %h valid %b exp 00000013/0", InstrD, ValidD); end
    PCSrcE = 1'b0; StallF = 1'b0; imem_if.IMemReady = 1'b1;
    tick();
    tests_run++; if (InstrD !== 32'h00500093 || PCD !== 32'h100 || PCPlus4D !== 32'h104) begin tests_failed++; $display("FAIL redir_land: got %h pc %h pc4 %h exp 00500093/100/104", InstrD, PCD, PCPlus4D); end
    tests_run++; if (imem_if.IMemAddr !== 32'h104) begin tests_failed++; $display("FAIL redir_next: got %h exp 00000104", imem_if.IMemAddr); end
  endtask

  task automatic test_stall_flush();
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (imem_if.IMemAddr !== 32'h104) begin tests_failed++; $display("FAIL stall%0d_pc: got %h exp 00000104", i, imem_if.IMemAddr); end
      tests_run++; if (InstrD !== 32'h00500093 || PCD !== 32'h100 || ValidD !== 1'b1 || SrcExtD !== 3'b001) begin tests_failed++; $display("FAIL stall%0d_d: instr %h pc %h valid %b srcext %b exp 00500093/100/1/001", i, InstrD, PCD, ValidD, SrcExtD); end
    end
    FlushD = 1'b1;
    tick();
    tests_run++; if (InstrD !== 32'h13 || ValidD !== 1'b0 || SrcExtD !== 3'b001) begin tests_failed++; $display("FAIL flush_bubble: instr %h valid %b srcext %b exp 00000013/0/001", InstrD, ValidD, SrcExtD); end
    tests_run++; if (PCD !== 32'h100 || imem_if.IMemAddr !== 32'h104) begin tests_failed++; $display("FAIL flush_hold: pcd %h pcf %h exp 00000100/00000104", PCD, imem_if.IMemAddr); end
    FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0;
    tick();
    tests_run++; if (InstrD !== 32'h00A00113 || PCD !== 32'h104 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL stall_resume: got %h pc %h valid %b exp 00a00113/104/1", InstrD, PCD, ValidD); end
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] words [8];
    logic [2:0]  sel   [8];
    logic [31:0] w;
    words = '{32'h00209093, 32'h00112023, 32'hFE000EE3, 32'h000012B7,
              32'h0080006F, 32'h002081B3, 32'h4010D093, 32'h00002083};
    sel   = '{3'b110, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110, 3'b001};
    PCSrcE = 1'b1; PCTargetE = 32'h220;
    tick();
    PCSrcE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      w = words[i];
      tests_run++; if (InstrD !== w || SrcExtD !== sel[i]) begin tests_failed++; $display("FAIL sweep%0d: instr %h srcext %b exp %h/%b", i, InstrD, SrcExtD, w, sel[i]); end
      tests_run++; if (ImmD !== w[31:7] || ValidD !== 1'b1 || PCD !== 32'h220 + 32'(4 * i)) begin tests_failed++; $display("FAIL sweep%0d_imm: imm %h valid %b pc %h exp %h/1/%h", i, ImmD, ValidD, PCD, w[31:7], 32'h220 + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin tests_failed++; $display("FAIL wrap_redir: pc %h valid %b exp fffffffc/0", imem_if.IMemAddr, ValidD); end
    PCSrcE = 1'b0;
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc: got %h exp 00000000", imem_if.IMemAddr); end
    tests_run++; if (InstrD !== 32'h00002083 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin tests_failed++; $display("FAIL wrap_d: instr %h pc %h pc4 %h exp 00002083/fffffffc/0", InstrD, PCD, PCPlus4D); end
  endtask

  task automatic test_async_reset();
    tick();
    tests_run++; if (imem_if.IMemAddr !== 32'h4 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL prerst: pc %h valid %b exp 00000004/1", imem_if.IMemAddr, ValidD); end
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if (imem_if.IMemAddr !== 32'h0 || ValidD !== 1'b0 || imem_if.IMemReq !== 1'b0) begin tests_failed++; $display("FAIL async_rst: pc %h valid %b req %b exp 0/0/0", imem_if.IMemAddr, ValidD, imem_if.IMemReq); end
    tests_run++; if (InstrD !== 32'h13) begin tests_failed++; $display("FAIL async_rst_instr: got %h exp 00000013", InstrD); end
    tick();
    rst_n = 1'b1;
    tests_run++; if (imem_if.IMemReq !== 1'b0) begin tests_failed++; $display("FAIL reboot_req: got %b exp 0", imem_if.IMemReq); end
    tick();
    tests_run++; if (imem_if.IMemReq !== 1'b1 || imem_if.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL reboot_fetch: req %b pc %h exp 1/00000000", imem_if.IMemReq, imem_if.IMemAddr); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_if.IMemReady = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h00500093; mem[1]  = 32'h00A00113; mem[2]  = 32'h00F00193;
    mem[8]  = 32'h00209093; mem[9]  = 32'h00112023; mem[10] = 32'hFE000EE3;
    mem[11] = 32'h000012B7; mem[12] = 32'h0080006F; mem[13] = 32'h002081B3;
    mem[14] = 32'h4010D093; mem[15] = 32'h00002083;

    test_reset();
    test_boot_fetch();
    test_mem_wait();
    test_redirect();
    test_stall_flush();
    test_opcode_sweep();
    test_wrap();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the RISC-V core.
- Holds the PC and fetches from instruction memory over a ready handshake.
- Registers the fetched instruction into decode together with the pre-decoded immediate-format select and immediate field.
- These feed the immediate extension unit directly as SrcExt and Imm[31:7].

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven on a bubble (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StallF  input  1  hold PC; do not accept a new fetch.
- StallD  input  1  hold the IF/ID register.
- FlushD  input  1  load a bubble into the IF/ID register.
- PCSrcE  input  1  redirect request from execute.
- PCTargetE  input  32  redirect target (branch/jump).
- IMemAddr  output  32  fetch address, equal to PCF.
- IMemReq  output  1  fetch request.
- IMemReady  input  1  IMemRdata valid this cycle (same-cycle read, wait states allowed).
- IMemRdata  input  32  instruction word.
- InstrD  output  32  decode-stage instruction.
- PCD  output  32  PC of InstrD.
- PCPlus4D  output  32  PCD+4.
- ImmD  output  25  InstrD[31:7], drives Imm[31:7] of the extension unit.
- SrcExtD  output  3  immediate format select, drives SrcExt.
- ValidD  output  1  InstrD is a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC; FSM=BOOT.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, SrcExtD=3'b001, ValidD=0, IMemReq=0.
  - ImmD=NOP_INSTR[31:7].
- FSM:
  - BOOT: IMemReq=0, PC held; next state FETCH unconditionally.
  - FETCH: IMemReq=1, IMemAddr=PCF; stays in FETCH until reset.
  - Reset mid-fetch returns to BOOT and drops the pending request.
- Fetch completes in a cycle when FSM=FETCH, IMemReady=1 and StallF=0.
- PC update priority, highest first:
  1. PCSrcE=1: PCF<=PCTargetE, regardless of IMemReady or StallF. The fetch in this cycle is discarded.
  2. StallF=1: hold.
  3. Fetch completes: PCF<=PCF+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  4. Otherwise hold.
- IF/ID register update priority, highest first:
  1. FlushD=1 or PCSrcE=1: bubble.
  2. StallD=1: hold all D outputs.
  3. Fetch completes: InstrD<=IMemRdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, SrcExtD<=decode(IMemRdata).
  4. Otherwise (BOOT, memory wait, or StallF=1 with StallD=0): bubble.
- Bubble: InstrD=NOP_INSTR, SrcExtD=3'b001, ValidD=0. PCD and PCPlus4D hold their previous values.
- ImmD is always InstrD[31:7].
- Latency: instruction at PCF appears on InstrD one edge after its fetch completes.
- Stall consistency: StallD=1 with StallF=0 and a completing fetch still advances the PC, which loses an instruction. The hazard unit never drives this combination; the bench flags it with an assertion.
- SrcExt decode on opcode [6:0]:
  - 0010011 with funct3 001 or 101 -> 110.
  - Other 0010011, plus 0000011 and 1100111 -> 001.
  - 0100011 -> 010.
  - 1100011 -> 011.
  - 0110111 and 0010111 -> 100.
  - 1101111 -> 101.
  - Any other opcode (R-type, system, illegal) -> 000.

Test Plan:
- Reset release, IMemReady=1, memory returns 0x00500093,0x00A00113: BOOT one cycle with IMemReq=0. IMemAddr then reads 0,4,8. InstrD=0x00500093 with PCD=0, SrcExtD=001, ValidD=1, then 0x00A00113 with PCD=4.
- IMemReady low for 3 cycles at PC=8: PCF holds at 8 and ValidD=0 for 3 cycles. The instruction then lands with PCD=8.
- PCSrcE=1 with PCTargetE=0x100 while IMemReady=0 and StallF=1: next PCF=0x100 and ValidD=0. The next fetch address is 0x100.
- StallF=StallD=1 for 2 cycles mid-stream: PCF and all D outputs hold. FlushD=1 while StallD=1 produces a bubble (InstrD=0x13, ValidD=0).
- Opcode sweep with words 0x00209093 (slli), 0x00112023 (sw), 0xFE000EE3 (beq), 0x000012B7 (lui), 0x0080006F (jal), 0x002081B3 (add): SrcExtD = 110, 010, 011, 100, 101, 000. ImmD = word[31:7] in each case.
- PCTargetE=0xFFFFFFFC, then a completed fetch: PCF wraps to 0x00000000. Async rst_n pulse mid-cycle immediately gives PCF=RESET_PC, ValidD=0, IMemReq=0.
